// File: rtl/raycast_pkg.sv
// Shared constants and types for the ray-cast front end.
// Angles are carried in eighths of a degree.
package raycast_pkg;

  localparam int SCREEN_W            = 160;
  localparam int FOV_DEG             = 60;
  localparam int ANGLE_FRAC_BITS     = 3;
  localparam int FULL_CIRCLE_EIGHTHS = 2880;
  localparam int HALF_FOV_EIGHTHS    = 240;
  localparam int STEP_EIGHTHS        = 3;
  localparam int ANGLE_W             = 12;
  localparam int DEG_W               = 9;
  localparam int SLICE_W             = 8;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/ray_angle_sequencer_if.sv
// Sequencer <-> host/caster signal bundle.
// master is the sequencer side, slave the host/caster side.
interface ray_angle_sequencer_if;
  import raycast_pkg::*;

  logic               frame_start;
  logic [DEG_W-1:0]   player_angle;
  logic               ray_ready;
  logic               ray_valid;
  logic [SLICE_W-1:0] slice_idx;
  logic [DEG_W-1:0]   ray_angle_int;
  logic [2:0]         ray_angle_frac;
  logic               busy;
  logic               frame_done;

  modport master (
    input  frame_start,
    input  player_angle,
    input  ray_ready,
    output ray_valid,
    output slice_idx,
    output ray_angle_int,
    output ray_angle_frac,
    output busy,
    output frame_done
  );

  modport slave (
    output frame_start,
    output player_angle,
    output ray_ready,
    input  ray_valid,
    input  slice_idx,
    input  ray_angle_int,
    input  ray_angle_frac,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/angle_wrap_add.sv
// Add or subtract two eighths-of-a-degree values modulo 360 deg.
// Both operands must already lie in [0, 2880).
module angle_wrap_add
  import raycast_pkg::*;
(
  input  angle_t a,
  input  angle_t b,
  input  logic   sub,
  output angle_t y
);

  localparam int SW = ANGLE_W + 1;
  localparam logic [SW-1:0] CIRCLE = SW'(FULL_CIRCLE_EIGHTHS);

  logic [SW-1:0] s;

  always_comb begin
    s = '0;
    if (sub) begin
      if (a < b) s = {1'b0, a} + CIRCLE - {1'b0, b};
      else       s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= CIRCLE) s = s - CIRCLE;
    end
    y = s[ANGLE_W-1:0];
  end

endmodule

// File: rtl/ray_angle_sequencer.sv
// Per-frame slice sequencer: emits one wrapped ray angle per
// screen column over a valid/ready handshake.
module ray_angle_sequencer
  import raycast_pkg::*;
#(
  parameter int NUM_SLICES = SCREEN_W
) (
  input  logic clk,
  input  logic reset,
  ray_angle_sequencer_if.master rif
);

  localparam logic [SLICE_W-1:0] LAST = SLICE_W'(NUM_SLICES - 1);

  state_t             state_q, state_d;
  angle_t             acc_q, acc_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DEG_W-1:0] p_adj;
  angle_t           wa, wb, wy;
  logic             wsub;
  logic             xfer;

  // One shared wrap unit: start angle in IDLE, step otherwise.
  angle_wrap_add u_wrap (
    .a   (wa),
    .b   (wb),
    .sub (wsub),
    .y   (wy)
  );

  always_comb begin
    p_adj = rif.player_angle;
    if (rif.player_angle >= DEG_W'(360))
      p_adj = rif.player_angle - DEG_W'(360);

    wa   = acc_q;
    wb   = angle_t'(STEP_EIGHTHS);
    wsub = 1'b0;
    if (state_q == IDLE) begin
      wa   = {p_adj, 3'b000};
      wb   = angle_t'(HALF_FOV_EIGHTHS);
      wsub = 1'b1;
    end
  end

  assign xfer = valid_q & rif.ray_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    slice_d = slice_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rif.frame_start) begin
          acc_d   = wy;
          slice_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (slice_q == LAST) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            slice_d = slice_q + SLICE_W'(1);
            acc_d   = wy;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      slice_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      slice_q <= slice_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rif.ray_valid      = valid_q;
  assign rif.slice_idx      = slice_q;
  assign rif.ray_angle_int  = acc_q[ANGLE_W-1:3];
  assign rif.ray_angle_frac = acc_q[2:0];
  assign rif.busy           = busy_q;
  assign rif.frame_done     = done_q;

endmodule
